sm_muldiv: RTL and testbench
============================

# sm_muldiv

Iterative multiply/divide sequencer for the schoolMIPS core. It owns the HI/LO register pair and runs unsigned 32-bit MULTU/DIVU as 32-iteration shift-add / restoring-divide sequences on one shared 64-bit accumulator. It also performs single-cycle MTHI/MTLO writes. It sits beside `sm_alu`: `sm_control` issues a one-cycle `start` and stalls PC update while `busy` is high.

## Interface
- `WIDTH`, default 32: operand width. HI/LO are each `WIDTH` bits. The iteration count equals `WIDTH`.
- `clk`  in  1  clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request strobe; sampled on the rising edge of `clk`.
- `op`  in  2  operation: `MD_MULTU`=2'b00, `MD_DIVU`=2'b01, `MD_MTHI`=2'b10, `MD_MTLO`=2'b11.
- `srcA`  in  WIDTH  multiplicand or dividend; data for MTHI/MTLO.
- `srcB`  in  WIDTH  multiplier or divisor.
- `flush`  in  1  abort the running operation.
- `busy`  out  1  high while MUL or DIV iterations are in progress.
- `done`  out  1  one-cycle pulse when a MULTU/DIVU result is committed.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation
- FSM states: `IDLE`, `MUL`, `DIV`. A 5-bit iteration counter `cnt` runs alongside.
- **Acceptance:** `start` is accepted only in `IDLE`. It is ignored in `MUL` and `DIV`, with no queuing.
- **MULTU accepted:**
  - accumulator ← {0, `srcB`}, operand ← `srcA`, `cnt` ← WIDTH-1, state → `MUL`.
  - Each `MUL` cycle: if `acc[0]`, then `acc[2W-1:W]` += operand with a 33-bit carry. Then the {carry, acc} word shifts right by 1.
- **DIVU accepted:**
  - accumulator ← {0, `srcA`}, operand ← `srcB`, state → `DIV`.
  - Each `DIV` cycle: shift acc left by 1, then compute trial = `acc[2W-1:W]` − operand on W+1 bits.
  - If trial is non-negative: upper half ← trial and `acc[0]` ← 1. Otherwise `acc[0]` ← 0.
- **Commit:** in the `MUL`/`DIV` cycle with `cnt`==0:
  - `hi` ← upper half and `lo` ← lower half.
  - For DIVU, `lo` holds the quotient and `hi` holds the remainder.
  - State → `IDLE` and `done` ← 1 for one cycle.
- **Divide by zero** needs no special case. The restoring algorithm yields `lo`=all ones and `hi`=`srcA`, after the full 32 cycles.
- **MTHI/MTLO accepted in `IDLE`:** `hi` (or `lo`) ← `srcA` at that edge. `busy` and `done` stay low and the state stays `IDLE`.
- **HI/LO hold:** `hi`/`lo` keep their previous values during iterations. Only the commit edge or an MTHI/MTLO edge updates them.
- **Flush:** `flush` in `MUL`/`DIV` forces `IDLE` at the next edge. No commit happens, `done` stays low and `hi`/`lo` are unchanged. `flush` in `IDLE` has no effect. `flush` has priority over `start` in the same cycle.
- **Reset:** asynchronous `rst_n` low forces:
  - state=`IDLE`, `cnt`=0, accumulator=0
  - `busy`=0, `done`=0, `hi`=0, `lo`=0
  
  This applies at any point, including mid-operation.

## Timing
- MULTU/DIVU accepted at edge T: `busy` is high from T through T+31. Commit happens at edge T+32, when `done`=1, `busy`=0 and `hi`/`lo` are valid. The total is 32 busy cycles.
- `busy` and `done` are registered outputs. `done` is never high together with `busy`.
- A new `start` is accepted in the same cycle `done` is high, because the state is already `IDLE`. Back-to-back operations therefore run with zero gap.
- MTHI/MTLO latency is 1 edge. The value is readable on `hi`/`lo` in the following cycle.
- There is no combinational path from any input to any output.

## Configuration
- `SM_CONFIG_MULDIV_DIVIDE_EN`
- **Defined:** DIVU is supported as described, and the `DIV` state and the subtract path are built.
- **Undefined:**
  - The `DIV` state and trial subtractor are not built.
  - `start` with `op`=`MD_DIVU` is accepted as a no-op: state stays `IDLE`, `busy`/`done` stay low, `hi`/`lo` are unchanged.
  - MULTU, MTHI and MTLO are unaffected.

## Structure
- In `sm_cpu.vh`:
  - `MD_MULTU`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`
  - state encodings `MD_IDLE`, `MD_MUL`, `MD_DIV`
  - the new CPU function codes `F_MULTU`, `F_DIVU`, `F_MFHI`, `F_MFLO`, `F_MTHI`, `F_MTLO`
- One sub-module, `sm_muldiv_dp`:
  - holds the 2W-bit accumulator, the W-bit operand register, and the (W+1)-bit add/subtract unit
  - takes step controls `load`, `step_mul`, `step_div`
- The top level `sm_muldiv` holds the FSM, the counter, `hi`/`lo` and the flush/reset logic.

## Test plan
- **MULTU max:** MULTU `srcA`=0xFFFFFFFF, `srcB`=0xFFFFFFFF → `busy` high for 32 cycles, then `done` pulse, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **DIVU:** DIVU 100/7 → after 32 busy cycles `lo`=14, `hi`=2. DIVU 5/0 → `lo`=0xFFFFFFFF, `hi`=5.
- **Back-to-back and ignored start:**
  - MULTU 3×4, then DIVU 9/2 issued in the `done` cycle → `hi`/`lo`=0/12, then 1/4 exactly 32 cycles later.
  - A `start` pulsed mid-operation is ignored and the result is unchanged.
- **MTHI/MTLO:** MTHI 0xA5A5A5A5 then MTLO 0x12345678 on consecutive cycles → `hi`/`lo` update one edge each, `busy` never rises.
- **Flush:** `hi`/`lo`=0x1/0x2, then MULTU 7×7, then `flush` at busy cycle 10 → `busy` low next cycle, no `done`, `hi`/`lo` stay 0x1/0x2.
- **Reset and config:**
  - `rst_n` low at busy cycle 20 → all outputs 0 immediately; after release, a new MULTU 2×3 gives `lo`=6.
  - With `SM_CONFIG_MULDIV_DIVIDE_EN` undefined, DIVU 100/7 → `busy`/`done` stay 0 and `hi`/`lo` are unchanged.

Source files
------------

// File: rtl/sm_muldiv_pkg.sv
// Shared encodings for the schoolMIPS multiply/divide sequencer: op codes,
// sequencer state encoding and the CPU function codes that feed it.
package sm_muldiv_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_DIVU  = 2'b01;
  localparam logic [1:0] MD_MTHI  = 2'b10;
  localparam logic [1:0] MD_MTLO  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10
  } md_state_e;

  // R-type function field values decoded by sm_control
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIVU  = 6'h1b;

endpackage

// File: rtl/sm_muldiv_dp.sv
// Datapath for sm_muldiv: 2W-bit accumulator, W-bit operand register and the
// shared add/subtract step. The divide path exists only with SM_CONFIG_MULDIV_DIVIDE_EN.
module sm_muldiv_dp
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 loadDiv,
  input  logic                 step_mul,
  input  logic                 step_div,
  input  logic [WIDTH-1:0]     srcA,
  input  logic [WIDTH-1:0]     srcB,
  output logic [2*WIDTH-1:0]   accNext
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [2*WIDTH-1:0] divNext;

  // Shift-add: the carry out of the upper-half add becomes the new MSB.
  always_comb begin
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    mulNext = {mulSum, acc[WIDTH-1:1]};
  end

`ifdef SM_CONFIG_MULDIV_DIVIDE_EN
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] trial;

  // The bit shifted out of the accumulator is kept as the partial remainder MSB,
  // so the compare stays exact for divisors with the top bit set.
  always_comb begin
    partial = acc[2*WIDTH-1:WIDTH-1];
    trial   = {1'b0, partial} - {2'b00, operand};
    if (trial[WIDTH+1])
      divNext = {acc[2*WIDTH-2:0], 1'b0};
    else
      divNext = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
`else
  assign divNext = acc;
`endif

  always_comb begin
    accNext = acc;
    if (step_mul)
      accNext = mulNext;
    else if (step_div)
      accNext = divNext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      operand <= '0;
    end else if (load) begin
      acc     <= loadDiv ? {{WIDTH{1'b0}}, srcA} : {{WIDTH{1'b0}}, srcB};
      operand <= loadDiv ? srcB : srcA;
    end else begin
      acc     <= accNext;
    end
  end

endmodule

// File: rtl/sm_muldiv.sv
// Iterative MULTU/DIVU sequencer owning HI/LO; MTHI/MTLO write in one edge.
// DIVU is built only when SM_CONFIG_MULDIV_DIVIDE_EN is defined.
module sm_muldiv
  import sm_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbgState
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e          state;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               loadDiv;
  logic               stepMul;
  logic               stepDiv;
  logic [2*WIDTH-1:0] accNext;

  // Handshake: start is taken only in IDLE; busy covers every iteration cycle,
  // done pulses on the commit edge and never overlaps busy.
  always_comb begin
    loadDiv = (op == MD_DIVU);
    load    = 1'b0;
    if (state == MD_IDLE && start) begin
`ifdef SM_CONFIG_MULDIV_DIVIDE_EN
      load = (op == MD_MULTU) || (op == MD_DIVU);
`else
      load = (op == MD_MULTU);
`endif
    end
    stepMul = (state == MD_MUL) && !flush;
`ifdef SM_CONFIG_MULDIV_DIVIDE_EN
    stepDiv = (state == MD_DIV) && !flush;
`else
    stepDiv = 1'b0;
`endif
  end

  sm_muldiv_dp #(.WIDTH(WIDTH)) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .loadDiv  (loadDiv),
    .step_mul (stepMul),
    .step_div (stepDiv),
    .srcA     (srcA),
    .srcB     (srcB),
    .accNext  (accNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            case (op)
              MD_MULTU: begin
                state <= MD_MUL;
                cnt   <= CNT_W'(WIDTH - 1);
                busy  <= 1'b1;
              end
`ifdef SM_CONFIG_MULDIV_DIVIDE_EN
              MD_DIVU: begin
                state <= MD_DIV;
                cnt   <= CNT_W'(WIDTH - 1);
                busy  <= 1'b1;
              end
`endif
              MD_MTHI: hi <= srcA;
              MD_MTLO: lo <= srcA;
              default: ;
            endcase
          end
        end
        MD_MUL, MD_DIV: begin
          if (flush) begin
            state <= MD_IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            // Commit the result of the final iteration directly.
            hi    <= accNext[2*WIDTH-1:WIDTH];
            lo    <= accNext[WIDTH-1:0];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= MD_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= MD_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbgState = state;

endmodule

// File: tb/tb_sm_muldiv.sv
// Directed bench for sm_muldiv: a vector table plus hand sequences for
// back-to-back, ignored start, flush, MTHI/MTLO and asynchronous reset.
module tb_sm_muldiv;
  import sm_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbgState;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          expBusy;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[10];

  sm_muldiv #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .srcA     (srcA),
    .srcB     (srcB),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .dbgState (dbgState)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives a one-cycle start; returns just after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts busy samples until done; optionally pulses a stray start at busy cycle injectAt.
  task automatic wait_done(input int injectAt, output int busyCnt, output bit gotDone);
    bit overlap;
    busyCnt = 0; gotDone = 0; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy && done) overlap = 1;
      if (done) begin gotDone = 1; break; end
      if (!busy) break;
      busyCnt++;
      if (busyCnt == injectAt) begin
        start = 1'b1; op = MD_MULTU; srcA = 32'd100; srcB = 32'd100;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done_busy_overlap", 64'(overlap), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int busyCnt, output bit gotDone);
    issue(o, a, b);
    wait_done(-1, busyCnt, gotDone);
  endtask

  initial begin
    int  bc;
    bit  gd;
    bit  sawDone;

    vecs[0] = '{MD_MTHI,  32'hDEADBEEF, 32'h0,        0,  32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{MD_MTLO,  32'hCAFEF00D, 32'h0,        0,  32'hDEADBEEF, 32'hCAFEF00D};
    vecs[2] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 32'hFFFFFFFE, 32'h00000001};
`ifdef SM_CONFIG_MULDIV_DIVIDE_EN
    vecs[3] = '{MD_DIVU,  32'd100,      32'd7,        32, 32'd2,        32'd14};
    vecs[4] = '{MD_DIVU,  32'd5,        32'd0,        32, 32'd5,        32'hFFFFFFFF};
`else
    vecs[3] = '{MD_DIVU,  32'd100,      32'd7,        0,  32'hFFFFFFFE, 32'h00000001};
    vecs[4] = '{MD_DIVU,  32'd5,        32'd0,        0,  32'hFFFFFFFE, 32'h00000001};
`endif
    vecs[5] = '{MD_MULTU, 32'h12345678, 32'h10,       32, 32'h00000001, 32'h23456780};
`ifdef SM_CONFIG_MULDIV_DIVIDE_EN
    vecs[6] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32, 32'h00000000, 32'hFFFFFFFF};
`else
    vecs[6] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        0,  32'h00000001, 32'h23456780};
`endif
    vecs[7] = '{MD_MULTU, 32'h0,        32'hABCDEF01, 32, 32'h00000000, 32'h00000000};
`ifdef SM_CONFIG_MULDIV_DIVIDE_EN
    vecs[8] = '{MD_DIVU,  32'd3,        32'd10,       32, 32'd3,        32'd0};
`else
    vecs[8] = '{MD_DIVU,  32'd3,        32'd10,       0,  32'h00000000, 32'h00000000};
`endif
    vecs[9] = '{MD_MULTU, 32'h80000000, 32'd2,        32, 32'h00000001, 32'h00000000};

    // Reset state
    #12;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_state", 64'(dbgState), 64'(MD_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, bc, gd);
      check($sformatf("vec%0d_busy_cycles", v), 64'(bc), 64'(vecs[v].expBusy));
      check($sformatf("vec%0d_done", v), 64'(gd), 64'(vecs[v].expBusy != 0));
      check($sformatf("vec%0d_hi", v), 64'(hi), 64'(vecs[v].expHi));
      check($sformatf("vec%0d_lo", v), 64'(lo), 64'(vecs[v].expLo));
    end

    // Back-to-back: DIVU issued while done of MULTU is high
    run_op(MD_MULTU, 32'd3, 32'd4, bc, gd);
    check("b2b_mul_done", 64'(gd), 64'd1);
    check("b2b_mul_hi", 64'(hi), 64'd0);
    check("b2b_mul_lo", 64'(lo), 64'd12);
    start = 1'b1; op = MD_DIVU; srcA = 32'd9; srcB = 32'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(-1, bc, gd);
`ifdef SM_CONFIG_MULDIV_DIVIDE_EN
    check("b2b_div_busy_cycles", 64'(bc), 64'd32);
    check("b2b_div_done", 64'(gd), 64'd1);
    check("b2b_div_hi", 64'(hi), 64'd1);
    check("b2b_div_lo", 64'(lo), 64'd4);
`else
    check("b2b_div_busy_cycles", 64'(bc), 64'd0);
    check("b2b_div_done", 64'(gd), 64'd0);
    check("b2b_div_hi", 64'(hi), 64'd0);
    check("b2b_div_lo", 64'(lo), 64'd12);
`endif

    // Start pulsed mid-operation is ignored
    issue(MD_MULTU, 32'd7, 32'd6);
    wait_done(5, bc, gd);
    check("ignore_busy_cycles", 64'(bc), 64'd32);
    check("ignore_done", 64'(gd), 64'd1);
    check("ignore_hi", 64'(hi), 64'd0);
    check("ignore_lo", 64'(lo), 64'd42);
    @(posedge clk); #1;
    check("ignore_done_pulse", 64'(done), 64'd0);
    check("ignore_idle_busy", 64'(busy), 64'd0);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; srcA = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("mthi_hi", 64'(hi), 64'hA5A5A5A5);
    check("mthi_lo", 64'(lo), 64'd42);
    check("mthi_busy", 64'(busy), 64'd0);
    op = MD_MTLO; srcA = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_hi", 64'(hi), 64'hA5A5A5A5);
    check("mtlo_lo", 64'(lo), 64'h12345678);
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mtlo_done", 64'(done), 64'd0);

    // Flush at busy cycle 10
    run_op(MD_MTHI, 32'h1, 32'h0, bc, gd);
    run_op(MD_MTLO, 32'h2, 32'h0, bc, gd);
    issue(MD_MULTU, 32'd7, 32'd7);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
    end
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_state", 64'(dbgState), 64'(MD_IDLE));
    sawDone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) sawDone = 1;
      @(posedge clk); #1;
    end
    check("flush_no_done", 64'(sawDone), 64'd0);
    check("flush_hi", 64'(hi), 64'h1);
    check("flush_lo", 64'(lo), 64'h2);

    // Asynchronous reset at busy cycle 20
    issue(MD_MULTU, 32'hFFFFFFFF, 32'd3);
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
    end
    check("rst_pre_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_state", 64'(dbgState), 64'(MD_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(MD_MULTU, 32'd2, 32'd3, bc, gd);
    check("post_rst_busy_cycles", 64'(bc), 64'd32);
    check("post_rst_done", 64'(gd), 64'd1);
    check("post_rst_hi", 64'(hi), 64'd0);
    check("post_rst_lo", 64'(lo), 64'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
